// File: rtl/mux_scan_pkg.sv
// Shared constants and FSM state type for the mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CH_W   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold,
    StFin
  } state_e;

endpackage

// File: rtl/next_chan_find.sv
// Combinational search for the next enabled channel: lowest set mask bit above cur,
// or lowest set bit overall when first=1.
module next_chan_find
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  input  logic              first,
  output logic [CH_W-1:0]   ch,
  output logic              found
);

  // Descending walk so the last hit (the lowest qualifying bit) wins.
  always_comb begin
    ch    = '0;
    found = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        ch    = CH_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 byte mux: steps sel over enabled channels, settles, captures,
// streams bytes with channel tags. Optional out_parity output under MUX_SCAN_PARITY_EN.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NUM_CH-1:0]  mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [CH_W-1:0]    sel,
  input  logic [DATA_W-1:0]  mux_data,
  output logic [DATA_W-1:0]  out_data,
  output logic [CH_W-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
`ifdef MUX_SCAN_PARITY_EN
  output logic               out_parity,
`endif
  output logic               done
);

  localparam int unsigned CntW = DWELL_W + 1;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    sel_q, sel_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef MUX_SCAN_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic              scan_idle;
  logic              launch;
  logic [NUM_CH-1:0] find_mask;
  logic [CH_W-1:0]   nxt_ch;
  logic              nxt_found;

  // FIN with done already shown is equivalent to IDLE for accepting a new start.
  assign scan_idle = (state_q == StIdle) || (state_q == StFin);
  assign launch    = start && ((state_q == StIdle) || ((state_q == StFin) && done_q));
  assign find_mask = scan_idle ? mask : mask_q;

  next_chan_find u_find (
    .mask  (find_mask),
    .cur   (sel_q),
    .first (scan_idle),
    .ch    (nxt_ch),
    .found (nxt_found)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      StIdle: ;
      StSettle: begin
        if (cnt_q == '0) begin
          data_d  = mux_data;
          ch_d    = sel_q;
          valid_d = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
          parity_d = ^mux_data;
`endif
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (nxt_found) begin
            sel_d   = nxt_ch;
            cnt_d   = CntW'(dwell_q);
            state_d = StSettle;
          end else begin
            sel_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StFin;
          end
        end
      end
      StFin: begin
        // Entered straight from IDLE (empty mask): raise done one cycle later.
        if (!done_q) begin
          sel_d  = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // The first channel gets one extra settle cycle so capture lands at start+2+dwell.
    if (launch) begin
      mask_d  = mask;
      dwell_d = dwell;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      if (nxt_found) begin
        sel_d   = nxt_ch;
        cnt_d   = CntW'(dwell) + CntW'(1);
        state_d = StSettle;
      end else begin
        state_d = StFin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef MUX_SCAN_PARITY_EN
  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized self-checking bench for mux_scan_ctrl against a timing-rule model of a scan.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] mask;
  logic [3:0] dwell;
  logic [2:0] sel;
  logic [7:0] mux_data;
  logic [7:0] out_data;
  logic [2:0] out_ch;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
`ifdef MUX_SCAN_PARITY_EN
  logic       out_parity;
`endif

  logic [7:0] mux_tab [8];
  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  // Behavioural 8:1 mux in front of the sequencer.
  assign mux_data = mux_tab[sel];

  mux_scan_ctrl #(.DWELL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mask      (mask),
    .dwell     (dwell),
    .sel       (sel),
    .mux_data  (mux_data),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef MUX_SCAN_PARITY_EN
    .out_parity(out_parity),
`endif
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_sel"}, sel, 0);
    check_eq({tag, "_data"}, out_data, 0);
    check_eq({tag, "_ch"}, out_ch, 0);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
`ifdef MUX_SCAN_PARITY_EN
    check_eq({tag, "_par"}, out_parity, 0);
`endif
  endtask

  // mode: 0 ready always 1, 1 random ready, 2 ready low for 10 valid cycles then high.
  task automatic run_scan(input logic [7:0] m, input logic [3:0] dw, input int mode,
                          input bit poke);
    int         q_ch[$];
    logic [7:0] q_d[$];
    int         k, exp_cap, exp_done, stall;
    bit         ended, v_prev, r_prev;
    logic [7:0] d_prev;
    logic [2:0] c_prev, s_prev;

    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        q_ch.push_back(i);
        q_d.push_back(mux_tab[i]);
      end
    end

    start     = 1'b1;
    mask      = m;
    dwell     = dw;
    out_ready = (mode != 2);
    @(posedge clk); #1;
    start = 1'b0;
    mask  = 8'($urandom);
    dwell = 4'($urandom);
    check_eq("busy_on_start", busy, 1);
    check_eq("valid_after_start", out_valid, 0);

    exp_cap  = 2 + int'(dw);
    exp_done = (q_ch.size() == 0) ? 1 : -1;
    k        = 0;
    stall    = 0;
    ended    = 1'b0;
    v_prev   = out_valid;
    d_prev   = out_data;
    c_prev   = out_ch;
    s_prev   = sel;

    while (!ended && k < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = (stall >= 10);
      endcase
      start  = poke && ($urandom_range(0, 2) == 0);
      r_prev = out_ready;
      @(posedge clk); #1;
      k++;
      start = 1'b0;

      if (v_prev && r_prev) begin
        if (q_ch.size() == 0) begin
          check_eq("extra_xfer", 1, 0);
        end else begin
          check_eq("xfer_ch", c_prev, q_ch[0]);
          check_eq("xfer_data", d_prev, q_d[0]);
          void'(q_ch.pop_front());
          void'(q_d.pop_front());
          check_eq("valid_clear", out_valid, 0);
          if (q_ch.size() == 0) begin
            exp_done = k;
          end else begin
            exp_cap = k + 1 + int'(dw);
            check_eq("next_sel", sel, q_ch[0]);
          end
        end
      end else if (v_prev) begin
        if (mode == 2) stall++;
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, d_prev);
        check_eq("hold_ch", out_ch, c_prev);
        check_eq("hold_sel", sel, s_prev);
      end

      if (!v_prev && out_valid) begin
        if (q_ch.size() == 0) begin
          check_eq("spurious_valid", 1, 0);
        end else begin
          check_eq("cap_edge", k, exp_cap);
          check_eq("cap_ch", out_ch, q_ch[0]);
          check_eq("cap_data", out_data, q_d[0]);
`ifdef MUX_SCAN_PARITY_EN
          check_eq("cap_parity", out_parity, ^q_d[0]);
`endif
        end
      end else if (!v_prev && !out_valid && q_ch.size() > 0 && k == exp_cap) begin
        check_eq("cap_missing", k, exp_cap + 1);
      end

      if (k == exp_done) begin
        check_eq("done_pulse", done, 1);
        check_eq("busy_fall", busy, 0);
        check_eq("sel_zero", sel, 0);
        ended = 1'b1;
      end else begin
        check_eq("no_early_done", done, 0);
        check_eq("busy_held", busy, 1);
      end

      v_prev = out_valid;
      d_prev = out_data;
      c_prev = out_ch;
      s_prev = sel;
    end
    if (!ended) check_eq("scan_timeout", 0, 1);

    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("done_once", done, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_valid", out_valid, 0);
  endtask

  task automatic reset_mid_hold();
    int w;
    start     = 1'b1;
    mask      = 8'h08;
    dwell     = 4'd1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!out_valid && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("rst_hold_valid", out_valid, 1);
    check_eq("rst_hold_ch", out_ch, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outs("async_rst");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_eq("rst_no_done", done, 0);
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_done", done, 0);
    check_eq("post_rst_busy", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    mask      = '0;
    dwell     = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) mux_tab[i] = 8'(i * 8'h11);
    #3;
    check_reset_outs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outs("idle");

    run_scan(8'hFF, 4'd0, 0, 1'b0);
    run_scan(8'b1010_0100, 4'd3, 0, 1'b0);
    run_scan(8'h16, 4'd2, 2, 1'b0);
    run_scan(8'h00, 4'd5, 0, 1'b0);
    run_scan(8'h5A, 4'd1, 0, 1'b1);

    reset_mid_hold();
    for (int i = 0; i < 8; i++) mux_tab[i] = 8'($urandom);
    run_scan(8'h28, 4'd2, 1, 1'b0);

    mux_tab[0] = 8'h07;
    mux_tab[1] = 8'h03;
    run_scan(8'h03, 4'd0, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 8; i++) mux_tab[i] = 8'($urandom);
      run_scan(8'($urandom), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
